// File: rtl/bubble_sort_seq.sv
// ============================================================================
//  Module      : bubble_sort_seq
//  Description : Sequential odd-even transposition sorter. Accepts one packed
//                vector of DIM unsigned elements, sorts it ascending or
//                descending, and counts the swaps it performed. One shared
//                network of floor(DIM/2) compare/swap pairs does one phase
//                per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bubble_sort_seq #(
    parameter int DIM   = 10,
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DIM*WIDTH-1:0] in_data,
    input  logic                 descend,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DIM*WIDTH-1:0] out_data,
    output logic [15:0]          swap_cnt
);

    // At least one pair slot so the arrays stay legal when DIM = 1.
    localparam int NPAIRS = (DIM / 2 > 0) ? DIM / 2 : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic [DIM-1:0][WIDTH-1:0]     data_q, data_d;
    logic                          desc_q, desc_d;
    logic [15:0]                   swap_cnt_q, swap_cnt_d;
    logic [6:0]                    phase_q, phase_d;
    logic                          prev_zero_q, prev_zero_d;

    logic                          w_phase_odd;
    logic [NPAIRS-1:0][WIDTH-1:0]  w_op_a;
    logic [NPAIRS-1:0][WIDTH-1:0]  w_op_b;
    logic [NPAIRS-1:0]             w_pair_en;
    logic [NPAIRS-1:0]             w_swap;
    logic [DIM-1:0][WIDTH-1:0]     w_sorted;
    logic [6:0]                    w_phase_swaps;
    logic [16:0]                   w_cnt_sum;

    assign w_phase_odd = phase_q[0];

    // Shared compare/swap pairs: operands are muxed between the even pairing
    // (2k,2k+1) and the odd pairing (2k+1,2k+2) depending on the phase.
    for (genvar k = 0; k < NPAIRS; k++) begin : g_pair
        if (2 * k + 1 < DIM) begin : g_live
            if (2 * k + 2 < DIM) begin : g_odd
                assign w_op_a[k]    = w_phase_odd ? data_q[2*k+1] : data_q[2*k];
                assign w_op_b[k]    = w_phase_odd ? data_q[2*k+2] : data_q[2*k+1];
                assign w_pair_en[k] = 1'b1;
            end else begin : g_no_odd
                // Top pair of an even-sized vector has no odd-phase partner.
                assign w_op_a[k]    = data_q[2*k];
                assign w_op_b[k]    = data_q[2*k+1];
                assign w_pair_en[k] = ~w_phase_odd;
            end
        end else begin : g_dead
            assign w_op_a[k]    = '0;
            assign w_op_b[k]    = '0;
            assign w_pair_en[k] = 1'b0;
        end
        // Strict compare so equal elements are never exchanged.
        assign w_swap[k] = w_pair_en[k] &
                           (desc_q ? (w_op_a[k] < w_op_b[k]) : (w_op_a[k] > w_op_b[k]));
    end

    // Route each element to its post-phase value from the pair it belongs to.
    for (genvar i = 0; i < DIM; i++) begin : g_elem
        logic [WIDTH-1:0] w_even_v;
        logic [WIDTH-1:0] w_odd_v;
        if (i % 2 == 0) begin : g_even_idx
            if (i + 1 < DIM) begin : g_lo
                assign w_even_v = w_swap[i/2] ? w_op_b[i/2] : data_q[i];
            end else begin : g_lone
                assign w_even_v = data_q[i];
            end
            if (i >= 2) begin : g_hi
                assign w_odd_v = w_swap[(i-2)/2] ? w_op_a[(i-2)/2] : data_q[i];
            end else begin : g_first
                assign w_odd_v = data_q[i];
            end
        end else begin : g_odd_idx
            assign w_even_v = w_swap[(i-1)/2] ? w_op_a[(i-1)/2] : data_q[i];
            if (i + 1 < DIM) begin : g_lo
                assign w_odd_v = w_swap[(i-1)/2] ? w_op_b[(i-1)/2] : data_q[i];
            end else begin : g_last
                assign w_odd_v = data_q[i];
            end
        end
        assign w_sorted[i] = w_phase_odd ? w_odd_v : w_even_v;
    end

    // Count the swaps of the current phase and form the unsaturated total.
    always_comb begin
        w_phase_swaps = '0;
        for (int k = 0; k < NPAIRS; k++) begin
            w_phase_swaps = w_phase_swaps + {6'd0, w_swap[k]};
        end
        w_cnt_sum = {1'b0, swap_cnt_q} + {10'd0, w_phase_swaps};
    end

    // Next-state and datapath updates for the IDLE/SORT/DONE controller.
    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        desc_d      = desc_q;
        swap_cnt_d  = swap_cnt_q;
        phase_d     = phase_q;
        prev_zero_d = prev_zero_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d      = in_data;
                    desc_d      = descend;
                    swap_cnt_d  = '0;
                    phase_d     = '0;
                    prev_zero_d = 1'b0;
                    state_d     = (DIM > 1) ? SORT : DONE;
                end
            end
            SORT: begin
                data_d      = w_sorted;
                swap_cnt_d  = w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
                phase_d     = phase_q + 7'd1;
                prev_zero_d = (w_phase_swaps == 7'd0);
                // Two consecutive quiet phases prove the vector is ordered.
                if ((phase_q == 7'(DIM - 1)) ||
                    ((phase_q != 7'd0) && (w_phase_swaps == 7'd0) && prev_zero_q)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            data_q      <= '0;
            desc_q      <= 1'b0;
            swap_cnt_q  <= '0;
            phase_q     <= '0;
            prev_zero_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            desc_q      <= desc_d;
            swap_cnt_q  <= swap_cnt_d;
            phase_q     <= phase_d;
            prev_zero_q <= prev_zero_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = data_q;
    assign swap_cnt  = swap_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_bubble_sort_seq.sv
// ============================================================================
//  Module      : tb_bubble_sort_seq
//  Description : Directed self-checking bench for bubble_sort_seq with
//                DIM=4, DIM=1 and DIM=10 instances.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bubble_sort_seq;

    logic clk;
    logic rst_n;

    // DIM = 4 instance
    logic        in_valid4, in_ready4, descend4, out_valid4, out_ready4;
    logic [31:0] in_data4, out_data4;
    logic [15:0] swap_cnt4;

    // DIM = 1 instance
    logic        in_valid1, in_ready1, descend1, out_valid1, out_ready1;
    logic [7:0]  in_data1, out_data1;
    logic [15:0] swap_cnt1;

    // DIM = 10 instance
    logic        in_valid10, in_ready10, descend10, out_valid10, out_ready10;
    logic [79:0] in_data10, out_data10;
    logic [15:0] swap_cnt10;

    int n_vec;
    int n_err;

    bubble_sort_seq #(.DIM(4), .WIDTH(8)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
        .descend(descend4), .out_valid(out_valid4), .out_ready(out_ready4),
        .out_data(out_data4), .swap_cnt(swap_cnt4)
    );

    bubble_sort_seq #(.DIM(1), .WIDTH(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .descend(descend1), .out_valid(out_valid1), .out_ready(out_ready1),
        .out_data(out_data1), .swap_cnt(swap_cnt1)
    );

    bubble_sort_seq #(.DIM(10), .WIDTH(8)) u_dut10 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid10), .in_ready(in_ready10), .in_data(in_data10),
        .descend(descend10), .out_valid(out_valid10), .out_ready(out_ready10),
        .out_data(out_data10), .swap_cnt(swap_cnt10)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] p4(input logic [7:0] e0, e1, e2, e3);
        return {e3, e2, e1, e0};
    endfunction

    // One transaction on the DIM=4 instance; returns after out_valid is seen.
    task automatic run4(input string tag, input logic [31:0] din, input logic d,
                        input logic [31:0] exp_d, input logic [15:0] exp_c, input int exp_lat);
        int w;
        int lat;
        w = 0;
        while (!in_ready4 && w < 50) begin
            @(posedge clk); #1; w++;
        end
        in_valid4 = 1'b1;
        in_data4  = din;
        descend4  = d;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        in_data4  = '0;
        lat = 0;
        while (!out_valid4 && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        chk({tag, "_lat"},  128'(lat),   128'(exp_lat));
        chk({tag, "_data"}, 128'(out_data4), 128'(exp_d));
        chk({tag, "_cnt"},  128'(swap_cnt4), 128'(exp_c));
        if (out_ready4) begin
            @(posedge clk); #1;
            chk({tag, "_idle"}, 128'({in_ready4, out_valid4}), 128'(2'b10));
        end
    endtask

    initial begin
        logic [31:0] held_d;
        logic [15:0] held_c;
        int          e[10];
        int          lat;
        int          inv;
        logic [79:0] exp10;

        n_vec = 0;
        n_err = 0;
        rst_n = 1'b1;
        in_valid4 = 0; in_data4 = '0; descend4 = 0; out_ready4 = 1;
        in_valid1 = 0; in_data1 = '0; descend1 = 0; out_ready1 = 1;
        in_valid10 = 0; in_data10 = '0; descend10 = 0; out_ready10 = 1;

        #1 rst_n = 1'b0;
        #2;
        chk("rst_ready", 128'(in_ready4), 128'(1));
        chk("rst_valid", 128'(out_valid4), 128'(0));
        chk("rst_data",  128'(out_data4), 128'(0));
        chk("rst_cnt",   128'(swap_cnt4), 128'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        run4("rev", p4(3, 1, 2, 0), 1'b0, p4(0, 1, 2, 3), 16'd5, 4);
        run4("ord", p4(5, 6, 7, 8), 1'b0, p4(5, 6, 7, 8), 16'd0, 2);
        run4("dsc", p4(5, 6, 7, 8), 1'b1, p4(8, 7, 6, 5), 16'd6, 4);
        run4("eq",  p4(9, 9, 1, 9), 1'b0, p4(1, 9, 9, 9), 16'd2, 4);

        // Back-pressure: result must hold and new offers must be ignored.
        out_ready4 = 1'b0;
        run4("hold", p4(5, 6, 7, 8), 1'b1, p4(8, 7, 6, 5), 16'd6, 4);
        held_d = out_data4;
        held_c = swap_cnt4;
        for (int i = 0; i < 10; i++) begin
            in_valid4 = i[0];
            in_data4  = p4(8'(i), 8'(i + 1), 8'hFF, 8'h00);
            descend4  = ~i[0];
            @(posedge clk); #1;
            chk("hold_valid", 128'(out_valid4), 128'(1));
            chk("hold_ready", 128'(in_ready4),  128'(0));
            chk("hold_data",  128'(out_data4),  128'(held_d));
            chk("hold_cnt",   128'(swap_cnt4),  128'(held_c));
        end
        in_valid4  = 1'b0;
        out_ready4 = 1'b1;
        @(posedge clk); #1;
        chk("hold_release", 128'({in_ready4, out_valid4}), 128'(2'b10));

        // Reset two cycles into SORT, checked before any clock edge.
        in_valid4 = 1'b1;
        in_data4  = p4(3, 1, 2, 0);
        descend4  = 1'b0;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_sort", 128'({in_ready4, out_valid4}), 128'(2'b00));
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready", 128'(in_ready4), 128'(1));
        chk("arst_valid", 128'(out_valid4), 128'(0));
        chk("arst_data",  128'(out_data4), 128'(0));
        chk("arst_cnt",   128'(swap_cnt4), 128'(0));
        @(posedge clk); #1 rst_n = 1'b1;
        run4("post_rst", p4(2, 1, 0, 3), 1'b0, p4(0, 1, 2, 3), 16'd3, 4);

        // DIM = 1: accept goes straight to DONE.
        in_valid1 = 1'b1;
        in_data1  = 8'hAB;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        chk("d1_valid", 128'(out_valid1), 128'(1));
        chk("d1_data",  128'(out_data1),  128'(8'hAB));
        chk("d1_cnt",   128'(swap_cnt1),  128'(0));
        @(posedge clk); #1;
        chk("d1_idle", 128'({in_ready1, out_valid1}), 128'(2'b10));

        // DIM = 10: random vectors against a reference sort and inversion count.
        for (int t = 0; t < 8; t++) begin
            descend10 = t[0];
            for (int i = 0; i < 10; i++) begin
                e[i] = (t >= 6) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 255));
                in_data10[i*8 +: 8] = 8'(e[i]);
            end
            if (t == 2) begin
                // Reverse-ordered worst case for ascending order.
                for (int i = 0; i < 10; i++) begin
                    e[i] = 200 - i * 10;
                    in_data10[i*8 +: 8] = 8'(e[i]);
                end
            end
            inv = 0;
            for (int i = 0; i < 10; i++)
                for (int j = i + 1; j < 10; j++)
                    if (t[0] ? (e[i] < e[j]) : (e[i] > e[j])) inv++;
            for (int i = 0; i < 10; i++)
                for (int j = 0; j < 9 - i; j++)
                    if (t[0] ? (e[j] < e[j+1]) : (e[j] > e[j+1])) begin
                        int tmp;
                        tmp = e[j]; e[j] = e[j+1]; e[j+1] = tmp;
                    end
            for (int i = 0; i < 10; i++) exp10[i*8 +: 8] = 8'(e[i]);
            in_valid10 = 1'b1;
            @(posedge clk); #1;
            in_valid10 = 1'b0;
            lat = 0;
            while (!out_valid10 && lat < 100) begin
                @(posedge clk); #1; lat++;
            end
            chk("d10_lat_max", 128'(lat <= 10 && lat >= 2), 128'(1));
            if (t == 2) chk("d10_worst_lat", 128'(lat), 128'(10));
            chk("d10_data", 128'(out_data10), 128'(exp10));
            chk("d10_cnt",  128'(swap_cnt10), 128'(inv));
            @(posedge clk); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bubble_sort_seq.md
BUBBLE_SORT_SEQ -- requirements
Module: bubble_sort_seq

Interface
REQ-001 SHALL have parameter DIM, default 10, number of elements per vector, legal range 1..64.
REQ-002 SHALL have parameter WIDTH, default 8, element width in bits, legal range 1..32.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  an input vector is offered.
REQ-006 SHALL have port in_ready  output  1  the block accepts a vector this cycle.
REQ-007 SHALL have port in_data  input  DIM*WIDTH  packed unsorted vector; element i at bits [WIDTH*(i+1)-1 : WIDTH*i].
REQ-008 SHALL have port descend  input  1  sort order: 0 ascending, 1 descending; sampled only on acceptance.
REQ-009 SHALL have port out_valid  output  1  the sorted vector is available.
REQ-010 SHALL have port out_ready  input  1  the consumer takes the result.
REQ-011 SHALL have port out_data  output  DIM*WIDTH  sorted vector, same packing as in_data.
REQ-012 SHALL have port swap_cnt  output  16  number of swaps performed for the current or last vector; saturates at 16'hFFFF.

Function
REQ-013 SHALL implement an FSM with states IDLE, SORT and DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE; an accept is in_valid & in_ready at a rising edge.
REQ-015 On accept, SHALL load in_data and descend, clear swap_cnt and the phase counter, and enter SORT (DIM>=2) or DONE (DIM=1).
REQ-016 In SORT, SHALL perform one odd-even transposition phase per cycle; even phases compare pairs (0,1),(2,3)...; odd phases compare pairs (1,2),(3,4)...; phase 0 is even.
REQ-017 Ascending mode SHALL swap a pair (j,j+1) only when elem[j] > elem[j+1], unsigned; descending mode only when elem[j] < elem[j+1]; equal elements are never swapped.
REQ-018 swap_cnt SHALL add the number of swaps made in each phase, with saturation.
REQ-019 SORT SHALL end after phase p when p = DIM-1, or when p >= 1 and phases p and p-1 both made zero swaps; the FSM then enters DONE.
REQ-020 Worst-case latency SHALL be DIM cycles from the accept edge to out_valid=1; an already-ordered vector with DIM>=2 SHALL take 2 cycles.
REQ-021 In DONE, SHALL hold out_valid=1 with out_data and swap_cnt stable until out_valid & out_ready, then return to IDLE on that edge.
REQ-022 out_valid SHALL be 0 in IDLE and SORT; out_data SHALL show the working register in all states.
REQ-023 in_valid, in_data and descend SHALL be ignored outside IDLE; a new vector offered during DONE is accepted no earlier than the cycle after the output handshake.
REQ-024 Logic SHALL be one comparator/swap network of floor(DIM/2) pairs reused every phase; no fully unrolled DIM-stage network.

Reset
REQ-025 When rst_n=0, SHALL immediately and asynchronously force state IDLE, in_ready=1, out_valid=0, out_data=0, swap_cnt=0 and phase counter=0.
REQ-026 Reset asserted during SORT or DONE SHALL discard the vector in progress; after rst_n returns to 1 the next accept starts cleanly.

Verification (DIM=4, WIDTH=8 unless noted; element 0 listed first)
REQ-027 Accept {3,1,2,0}, descend=0, out_ready=1 -> out_data {0,1,2,3}, swap_cnt=5, out_valid on the 4th edge after accept.
REQ-028 Accept {5,6,7,8}, descend=0 -> out_data {5,6,7,8}, swap_cnt=0, out_valid 2 cycles after accept (early exit).
REQ-029 Accept {5,6,7,8}, descend=1 -> out_data {8,7,6,5}, swap_cnt=6; then {9,9,1,9}, descend=0 -> {1,9,9,9}, swap_cnt=2; equal elements are not swapped.
REQ-030 Hold out_ready=0 for 10 cycles after out_valid -> out_valid, out_data and swap_cnt stable, in_ready=0, in_valid pulses ignored; raise out_ready -> IDLE the next cycle.
REQ-031 Pull rst_n low 2 cycles into SORT -> outputs reach their reset values without a clock edge; after release, accept {2,1,0,3} -> {0,1,2,3}.
REQ-032 DIM=1: accept {0xAB} -> out_data {0xAB}, swap_cnt=0, out_valid 1 cycle after accept; DIM=10 random vectors checked against a reference sort, in both modes.
